// File: rtl/scan_frame_capture.sv
// Rebuilds the 8x8 RGB frame shown on a row-multiplexed LED scan bus into a
// double-buffered pixel store. A row is taken once it has been stable for
// SETTLE_CYCLES. Row 7 commits the whole frame. Out-of-order rows are flagged.
module scan_frame_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       COMM,
    input  logic [7:0]       Data_R,
    input  logic [7:0]       Data_G,
    input  logic [7:0]       Data_B,
    input  logic             E,
    input  logic [2:0]       rd_row,
    output logic [7:0]       rd_R,
    output logic [7:0]       rd_G,
    output logic [7:0]       rd_B,
    output logic             frame_valid,
    output logic             frame_done,
    output logic             scan_error,
    output logic [CNT_W-1:0] frame_count
);

    localparam logic [7:0] SETTLE_V = 8'(SETTLE_CYCLES);

    typedef enum logic {
        SYNC    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // Sampled bus {COMM, R, G, B} and its value one cycle earlier.
    logic [26:0] smp_q, prv_q;

    logic [7:0]  cnt_q, cnt_d;
    logic        captured_q, captured_d;
    logic        row_evt;

    state_t      state_q, state_d;
    logic [2:0]  exp_q, exp_d;
    logic        wr_en, commit, err;

    // Pixel rows packed as {R, G, B}, active-high.
    logic [23:0] shadow_q [8];
    logic [23:0] frame_q  [8];
    logic [23:0] rd_q;

    logic             frame_valid_q, frame_done_q, scan_error_q;
    logic [CNT_W-1:0] frame_count_q;

    logic        scan_diff;
    logic [2:0]  evt_row;
    logic [23:0] evt_pix;

    assign scan_diff = (smp_q != prv_q);
    assign evt_row   = smp_q[26:24];
    assign evt_pix   = ~smp_q[23:0];

    // Register the scan bus and keep the previous sample for the stability compare.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            smp_q <= '0;
            prv_q <= '0;
        end else begin
            smp_q <= {COMM, Data_R, Data_G, Data_B};
            prv_q <= smp_q;
        end
    end

    // Settle counter: one row event per stable visit, on the cycle the count reaches SETTLE.
    always_comb begin
        cnt_d      = cnt_q;
        captured_d = captured_q;
        row_evt    = 1'b0;
        if (scan_diff) begin
            cnt_d      = 8'd0;
            captured_d = 1'b0;
        end else if (!E) begin
            cnt_d = 8'd0;
        end else if (cnt_q < SETTLE_V) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == SETTLE_V && !captured_q) begin
                row_evt    = 1'b1;
                captured_d = 1'b1;
            end
        end
    end

    // Settle counter and captured flag state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= 8'd0;
            captured_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
        end
    end

    // Scan-order tracking: decide shadow writes, commits and order errors per row event.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        err     = 1'b0;
        if (!E) begin
            state_d = SYNC;
            exp_d   = 3'd0;
        end else if (row_evt) begin
            case (state_q)
                SYNC: begin
                    if (evt_row == 3'd0) begin
                        wr_en   = 1'b1;
                        exp_d   = 3'd1;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (evt_row == exp_q) begin
                        wr_en = 1'b1;
                        if (exp_q == 3'd7) begin
                            commit  = 1'b1;
                            exp_d   = 3'd0;
                            state_d = SYNC;
                        end else begin
                            exp_d = exp_q + 3'd1;
                        end
                    end else begin
                        err = 1'b1;
                        // A stray row 0 restarts the frame right away.
                        if (evt_row == 3'd0) begin
                            wr_en   = 1'b1;
                            exp_d   = 3'd1;
                            state_d = CAPTURE;
                        end else begin
                            exp_d   = 3'd0;
                            state_d = SYNC;
                        end
                    end
                end
                default: begin
                    exp_d   = 3'd0;
                    state_d = SYNC;
                end
            endcase
        end
    end

    // State register and expected-row pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SYNC;
            exp_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    // Shadow buffer collects the frame under construction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
        end else if (wr_en) begin
            shadow_q[evt_row] <= evt_pix;
        end
    end

    // Committed buffer: rows 0..6 from shadow, row 7 straight from the bus in the commit cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) frame_q[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < 7; i++) frame_q[i] <= shadow_q[i];
            frame_q[7] <= evt_pix;
        end
    end

    // Registered readout of the committed frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q <= '0;
        end else begin
            rd_q <= frame_q[rd_row];
        end
    end

    // Frame status: pulses, sticky valid and wrapping frame counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            scan_error_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q  <= commit;
            scan_error_q  <= err;
            frame_valid_q <= frame_valid_q | commit;
            if (commit) frame_count_q <= frame_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rd_R        = rd_q[23:16];
    assign rd_G        = rd_q[15:8];
    assign rd_B        = rd_q[7:0];
    assign frame_valid = frame_valid_q;
    assign frame_done  = frame_done_q;
    assign scan_error  = scan_error_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_scan_frame_capture.sv
// Bench for scan_frame_capture: drives row visits on the scan bus, keeps a
// row-visit level model of frame assembly, and compares readout and status.
// Counter width reduced so frame_count wrap is reachable.
module tb_scan_frame_capture;

    localparam int S  = 4;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [2:0]    COMM;
    logic [7:0]    Data_R, Data_G, Data_B;
    logic          E;
    logic [2:0]    rd_row;
    logic [7:0]    rd_R, rd_G, rd_B;
    logic          frame_valid, frame_done, scan_error;
    logic [CW-1:0] frame_count;

    scan_frame_capture #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .COMM(COMM),
        .Data_R(Data_R), .Data_G(Data_G), .Data_B(Data_B), .E(E),
        .rd_row(rd_row), .rd_R(rd_R), .rd_G(rd_G), .rd_B(rd_B),
        .frame_valid(frame_valid), .frame_done(frame_done),
        .scan_error(scan_error), .frame_count(frame_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen  = 0;

    // Reference model state (frames of {R,G,B} active-high rows).
    logic [23:0] m_sh [8];
    logic [23:0] m_fr [8];
    bit          m_cap;
    int          m_exp, m_fc, m_done, m_err;
    bit          m_valid;
    logic [26:0] last_pins;

    // Pulse counters: every high cycle counts, so a stretched pulse is seen as extra.
    always @(negedge CLK) begin
        if (!RST) begin
            if (frame_done) done_seen++;
            if (scan_error) err_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sh[i] = '0;
            m_fr[i] = '0;
        end
        m_cap = 0; m_exp = 0; m_fc = 0; m_valid = 0;
    endtask

    // Frame assembly rules applied once per captured row visit.
    task automatic model_row(input int c, input logic [23:0] px);
        if (!m_cap) begin
            if (c == 0) begin
                m_sh[0] = px; m_exp = 1; m_cap = 1;
            end
        end else if (c == m_exp) begin
            m_sh[c] = px;
            if (c == 7) begin
                m_fr = m_sh;
                m_fc++; m_done++; m_valid = 1;
                m_cap = 0; m_exp = 0;
            end else begin
                m_exp++;
            end
        end else begin
            m_err++;
            if (c == 0) begin
                m_sh[0] = px; m_exp = 1;
            end else begin
                m_cap = 0; m_exp = 0;
            end
        end
    endtask

    // Hold one row on the bus for dwell cycles (long enough to be captured).
    task automatic visit(input int c, input logic [23:0] px_in, input int dwell);
        logic [2:0]  cc;
        logic [23:0] px;
        cc = 3'(c);
        px = px_in;
        if ({cc, ~px} == last_pins) px[16] = ~px[16];
        E      = 1'b1;
        COMM   = cc;
        Data_R = ~px[23:16];
        Data_G = ~px[15:8];
        Data_B = ~px[7:0];
        last_pins = {cc, ~px};
        repeat (dwell) @(negedge CLK);
        model_row(c, px);
    endtask

    task automatic drop_e(input int n);
        E = 1'b0;
        repeat (n) @(negedge CLK);
        m_cap = 0; m_exp = 0;
    endtask

    task automatic full_scan();
        for (int r = 0; r < 8; r++) visit(r, 24'($urandom), S + 2 + int'($urandom_range(3, 0)));
    endtask

    task automatic check_all(input string tag);
        repeat (4) @(negedge CLK);
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            @(negedge CLK);
            chk($sformatf("%s_row%0d", tag, r), {8'd0, rd_R, rd_G, rd_B}, {8'd0, m_fr[r]});
        end
        chk({tag, "_done_cnt"}, done_seen, m_done);
        chk({tag, "_err_cnt"}, err_seen, m_err);
        chk({tag, "_valid"}, {31'd0, frame_valid}, {31'd0, m_valid});
        chk({tag, "_count"}, {28'd0, frame_count}, 32'(m_fc % (1 << CW)));
    endtask

    initial begin
        logic [23:0] a, f;
        int c, last_c;

        RST = 1'b1; E = 1'b0; COMM = 3'd0;
        Data_R = 8'hFF; Data_G = 8'hFF; Data_B = 8'hFF;
        rd_row = 3'd0; last_pins = '1;
        model_reset();
        m_done = 0; m_err = 0;
        repeat (3) @(negedge CLK);
        chk("rst_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, scan_error}, 32'd0);
        chk("rst_count", {28'd0, frame_count}, 32'd0);
        chk("rst_rd", {8'd0, rd_R, rd_G, rd_B}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Clean scan: row r lights red columns equal to r.
        for (int r = 0; r < 8; r++) visit(r, {8'(r), 16'h0000}, 10);
        check_all("clean");

        // Bounce on row 3: only the settled value is stored, captured once.
        for (int r = 0; r < 3; r++) visit(r, 24'($urandom), 10);
        a = 24'($urandom);
        for (int k = 0; k < 4; k++) begin
            COMM   = 3'd3;
            f      = (k % 2 == 1) ? (a ^ 24'h010101) : a;
            Data_R = ~f[23:16]; Data_G = ~f[15:8]; Data_B = ~f[7:0];
            last_pins = {3'd3, ~f};
            repeat (2) @(negedge CLK);
        end
        visit(3, 24'($urandom), 10);
        for (int r = 4; r < 8; r++) visit(r, 24'($urandom), 10);
        check_all("bounce");

        // Skipped row 3: error at row 4, nothing committed; next clean scan commits.
        visit(0, 24'($urandom), 10);
        visit(1, 24'($urandom), 10);
        visit(2, 24'($urandom), 10);
        visit(4, 24'($urandom), 10);
        check_all("skip");
        full_scan();
        check_all("skip_recover");

        // Start mid-scan: 5,6,7 ignored in sync, then a full frame.
        for (int r = 5; r < 8; r++) visit(r, 24'($urandom), 9);
        full_scan();
        check_all("midscan");

        // Enable dropped during row 4: partial frame abandoned silently.
        for (int r = 0; r < 5; r++) visit(r, 24'($urandom), 9);
        drop_e(20);
        full_scan();
        check_all("edrop");

        // Randomized scan order with occasional enable drops.
        last_c = 7;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(99, 0) < 85) c = (last_c + 1) % 8;
            else c = int'($urandom_range(7, 0));
            visit(c, 24'($urandom), S + 2 + int'($urandom_range(4, 0)));
            last_c = c;
            if ($urandom_range(99, 0) < 4) begin
                drop_e(int'($urandom_range(15, 1)));
                last_c = 7;
            end
            if (n % 50 == 49) check_all($sformatf("rand%0d", n));
        end

        // Enough back-to-back frames to wrap the counter.
        for (int k = 0; k < 17; k++) full_scan();
        check_all("wrap");

        // Reset in the middle of a frame after earlier commits.
        for (int r = 0; r < 4; r++) visit(r, 24'($urandom), 9);
        #2;
        RST = 1'b1;
        E   = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, frame_valid}, 32'd0);
        chk("midrst_count", {28'd0, frame_count}, 32'd0);
        chk("midrst_rd", {8'd0, rd_R, rd_G, rd_B}, 32'd0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_all("midrst");
        // Back in sync: rows 1,2 are ignored without error.
        visit(1, 24'($urandom), 9);
        visit(2, 24'($urandom), 9);
        check_all("midrst_sync");
        full_scan();
        check_all("midrst_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_frame_capture.md
Name: scan_frame_capture

Overview:
- Receive-side counterpart of the 8x8 RGB LED matrix row scanner.
- Monitors the multiplexed scan bus (COMM row select, active-low Data_R/G/B column lines, E enable) and rebuilds the displayed 8x8 RGB frame into a double-buffered pixel store.
- Flags complete frames and scan-order errors.
- Used for on-chip self-check of the display path and for feeding the displayed image to other logic.

Parameters:
SETTLE_CYCLES, 4, consecutive CLK cycles COMM and data must be unchanged before a row is captured (1..255)
CNT_W, 16, width of frame_count

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
COMM  input  3  scanned row index, same domain as CLK
Data_R  input  8  red column lines, active-low, bit i = column i
Data_G  input  8  green column lines, active-low
Data_B  input  8  blue column lines, active-low
E  input  1  scan enable, active-high; capture only when 1
rd_row  input  3  row of committed frame to read
rd_R  output  8  committed red pixels of rd_row, active-high (1 = lit)
rd_G  output  8  committed green pixels, active-high
rd_B  output  8  committed blue pixels, active-high
frame_valid  output  1  1 once at least one complete frame is committed
frame_done  output  1  one-cycle pulse on each commit
scan_error  output  1  one-cycle pulse on out-of-order row
frame_count  output  CNT_W  committed frames, wraps at 2^CNT_W

Behaviour:
- Reset, asynchronous on RST high:
  - State SYNC; shadow and committed buffers all 0 (all pixels off).
  - rd_R/G/B = 0, frame_valid = 0, frame_done = 0, scan_error = 0, frame_count = 0.
  - Settle counter = 0, captured flag = 0, expected row = 0.
- Input registering: COMM and the 24 data bits are registered once per CLK.
- Stability:
  - Registered {COMM, data} is compared with its previous value each cycle.
  - Any difference clears the settle counter and the captured flag.
  - Otherwise the counter increments, saturating at SETTLE_CYCLES.
- Row event: fires in the cycle the counter reaches SETTLE_CYCLES with captured = 0 and E = 1. It sets captured = 1, so each row visit is captured exactly once regardless of dwell time.
- Pixel conversion: stored pixel = bitwise inverse of the column line (active-low to active-high).
- State machine:
  - SYNC: a row event with COMM = 0 writes shadow row 0, sets expected = 1, and goes to CAPTURE. Row events with COMM != 0 are ignored silently (no scan_error).
  - CAPTURE, row event with COMM = expected and expected < 7: write shadow row, expected += 1.
  - CAPTURE, row event with COMM = 7 = expected: write shadow row 7 and commit in the same cycle (shadow and the new row 7 copied to committed buffer). frame_done = 1 for one cycle, frame_count += 1, frame_valid = 1 (sticky until reset). Next state SYNC with expected = 0.
  - CAPTURE, row event with COMM != expected: scan_error = 1 for one cycle, shadow contents discarded (not committed). If COMM = 0, treat it as the SYNC capture of row 0 and stay in CAPTURE with expected = 1; else go to SYNC.
- E low in any state: settle counter held at 0, no row events. A CAPTURE in progress aborts to SYNC with no scan_error and no commit.
- Readout:
  - rd_R/G/B registered: the value present on the cycle after rd_row is applied.
  - A read at the same edge as a commit returns pre-commit data; the next cycle returns new data.
- Latency: a row stable from cycle t on the pins appears in shadow at t + 1 + SETTLE_CYCLES. A commit is visible on rd_* two cycles after the row-7 event.
- frame_count wraps from all-ones to 0 without any flag.
- Reset mid-frame clears everything, including the committed buffer.

Test Plan:
- Clean scan, SETTLE=4, each row held 10 cycles, E=1; row r lit columns = r, so Data_R = ~r and G = B = 8'hFF. Required: frame_done pulses once after row 7. Reading rows 0..7 gives rd_R = 0..7, rd_G = rd_B = 0. frame_valid = 1, frame_count = 1.
- Bounce: row 3 data toggles every 2 cycles for 8 cycles, then is stable. Required: only the final stable value is stored and row 3 is captured once.
- Skip: rows 0,1,2,4 scanned. Required: scan_error pulses at the row-4 event, no frame_done, and the committed buffer is unchanged. The next 0..7 sequence commits with frame_count = 1.
- Start mid-scan: first rows seen are 5,6,7,0..7. Required: no scan_error, and exactly one frame_done after the second row 7.
- E dropped during row 4 for 20 cycles, then a full scan. Required: no scan_error, and the partial frame is not committed. Only the full scan commits.
- RST asserted mid-CAPTURE after a prior commit. Required: rd_* = 0 for all rows, frame_valid = 0, frame_count = 0, and the state returns to SYNC.
